// File: rtl/pipe_ctrl.sv
// Central pipeline controller: hold-flag arbitration, jump pass-through,
// flush stretching, debug halt handshake and a saturating stall counter.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_ex_i,
  input  logic             hold_flag_clint_i,
  input  logic             hold_flag_rib_i,
  input  logic             halt_req_i,
  input  logic             cnt_clr_i,
  output logic [2:0]       hold_flag_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic             halt_ack_o,
  output logic             flush_active_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;
  localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
  localparam logic       FLUSH_EN     = (FLUSH_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_flush_cnt;
  logic [3:0]       w_flush_cnt_nxt;
  logic             r_halt_ack;
  logic             r_flush_active;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [2:0]       w_req_lvl;
  logic [2:0]       w_fsm_lvl;
  logic [2:0]       w_hold;

  function automatic logic [2:0] hold_max(input logic [2:0] a, input logic [2:0] b);
    hold_max = (a > b) ? a : b;
  endfunction

  // Request and FSM hold levels merged into the shared hold bus
  always_comb begin
    w_req_lvl = HOLD_NONE;
    w_fsm_lvl = HOLD_NONE;
    if (jump_flag_i || hold_flag_ex_i || hold_flag_clint_i) begin
      w_req_lvl = HOLD_ID;
    end else if (hold_flag_rib_i) begin
      w_req_lvl = HOLD_PC;
    end else begin
      w_req_lvl = HOLD_NONE;
    end
    case (r_state)
      ST_FLUSH: w_fsm_lvl = HOLD_ID;
      ST_HALT:  w_fsm_lvl = HOLD_PC;
      default:  w_fsm_lvl = HOLD_NONE;
    endcase
    w_hold = hold_max(w_req_lvl, w_fsm_lvl);
  end

  assign hold_flag_o    = w_hold;
  assign jump_flag_o    = jump_flag_i;
  assign jump_addr_o    = jump_flag_i ? jump_addr_i : 32'h0000_0000;
  assign halt_ack_o     = r_halt_ack;
  assign flush_active_o = r_flush_active;
  assign stall_cnt_o    = r_stall_cnt;

  // Next-state logic; a halt only starts from IDLE and never splits mul/div or irq entry
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      ST_IDLE: begin
        if (jump_flag_i && FLUSH_EN) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FLUSH_RELOAD;
        end else if (halt_req_i && !hold_flag_ex_i && !hold_flag_clint_i) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (jump_flag_i) begin
          w_flush_cnt_nxt = FLUSH_RELOAD;
        end else if (r_flush_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end
      ST_HALT: begin
        if (!halt_req_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_flush_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State, flush counter and status flags registered from next-state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_flush_cnt    <= 4'd0;
      r_halt_ack     <= 1'b0;
      r_flush_active <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_flush_cnt    <= w_flush_cnt_nxt;
      r_halt_ack     <= (w_state_nxt == ST_HALT);
      r_flush_active <= (w_state_nxt == ST_FLUSH);
    end
  end

  // Saturating stall-cycle counter; clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_stall_cnt <= '0;
    end else if ((w_hold != HOLD_NONE) && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_flag_ex_i = 1'b0;
  logic        hold_flag_clint_i = 1'b0;
  logic        hold_flag_rib_i = 1'b0;
  logic        halt_req_i = 1'b0;
  logic        cnt_clr_i = 1'b0;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        halt_ack_o;
  logic        flush_active_o;
  logic [3:0]  stall_cnt_o;

  pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .jump_flag_i      (jump_flag_i),
    .jump_addr_i      (jump_addr_i),
    .hold_flag_ex_i   (hold_flag_ex_i),
    .hold_flag_clint_i(hold_flag_clint_i),
    .hold_flag_rib_i  (hold_flag_rib_i),
    .halt_req_i       (halt_req_i),
    .cnt_clr_i        (cnt_clr_i),
    .hold_flag_o      (hold_flag_o),
    .jump_flag_o      (jump_flag_o),
    .jump_addr_o      (jump_addr_o),
    .halt_ack_o       (halt_ack_o),
    .flush_active_o   (flush_active_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          id;
    logic [2:0]  hold;
    logic        jf;
    logic [31:0] ja;
    logic        ack;
    logic        fl;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   step_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s: got 0x%0h expected 0x%0h", id, what, act, exp);
    end
  endtask

  // Monitor: compare the expectation stamped for this cycle
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.id, "hold_flag", 32'(hold_flag_o), 32'(e.hold));
      chk(e.id, "jump_flag", 32'(jump_flag_o), 32'(e.jf));
      chk(e.id, "jump_addr", jump_addr_o, e.ja);
      chk(e.id, "halt_ack", 32'(halt_ack_o), 32'(e.ack));
      chk(e.id, "flush_active", 32'(flush_active_o), 32'(e.fl));
      chk(e.id, "stall_cnt", 32'(stall_cnt_o), 32'(e.cnt));
    end
  end

  task automatic step(input logic r, input logic jf, input logic [31:0] ja,
                      input logic ex, input logic cl, input logic rib,
                      input logic hr, input logic clr,
                      input logic [2:0] eh, input logic ea, input logic ef,
                      input logic [3:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    jump_flag_i       = jf;
    jump_addr_i       = ja;
    hold_flag_ex_i    = ex;
    hold_flag_clint_i = cl;
    hold_flag_rib_i   = rib;
    halt_req_i        = hr;
    cnt_clr_i         = clr;
    e.cyc  = cyc;
    e.id   = step_id;
    e.hold = eh;
    e.jf   = jf;
    e.ja   = jf ? ja : 32'h0;
    e.ack  = ea;
    e.fl   = ef;
    e.cnt  = ec;
    sb.push_back(e);
    step_id++;
  endtask

  initial begin
    // Reset with all inputs low, then release
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    // Single jump
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 4'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 4'd2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd3);
    // Back-to-back jumps restart the flush stretch
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 4'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 4'd2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 4'd3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd4);
    // Request priority
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 4'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 4'd2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 4'd3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd4);
    // Halt blocked by EX, then granted
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 4'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 4'd2);
    step(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 4'd3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 4'd4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 4'd5);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd6);
    // Re-enter HALT, then reset mid-HALT
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd6);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 4'd6);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    // Jump and halt together: flush first, halt afterwards
    step(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 4'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 4'd2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 4'd3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 4'd4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd5);
    // Counter saturation at 15 with constant RIB hold
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0,
           (i > 15) ? 4'd15 : 4'(i));
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd15);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd1);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never compared, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
